// File: rtl/dma_axi_wr_engine.sv
// dma_axi_wr_engine: DMA write-side burst engine on an AXI4 write port.
// Splits one command into INCR bursts that never cross a 4 KB page.
module dma_axi_wr_engine #(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 20,
   parameter int MAX_BURST = 16,
   parameter int MAX_OUTST = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [LEN_W-1:0]    cmd_beats,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   output logic                done,
   output logic                done_err,
   output logic                busy,
   output logic                aw_valid,
   input  logic                aw_ready,
   output logic [ADDR_W-1:0]   aw_addr,
   output logic [7:0]          aw_len,
   output logic [2:0]          aw_size,
   output logic [1:0]          aw_burst,
   output logic [3:0]          aw_id,
   output logic                w_valid,
   input  logic                w_ready,
   output logic [DATA_W-1:0]   w_data,
   output logic [DATA_W/8-1:0] w_strb,
   output logic                w_last,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [1:0]          b_resp
);

   localparam int NB   = DATA_W / 8;
   localparam int SZ   = $clog2(NB);
   localparam int BL_W = $clog2(MAX_BURST) + 1;
   localparam int OS_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ADDR,
      S_DATA,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [BL_W-1:0]   bl_q, bl_d;
   logic [BL_W-1:0]   beat_q, beat_d;
   logic [OS_W-1:0]   outst_q, outst_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;

   logic [12:0]       room_bytes;
   logic [12:0]       room_beats;
   logic [12:0]       lim;
   logic              aw_hs;
   logic              b_hs;
   logic              b_err;

   // Burst length: limited by remaining beats, MAX_BURST and the 4 KB page.
   always_comb begin
      room_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
      room_beats = room_bytes >> SZ;
      lim        = 13'(MAX_BURST);
      if (room_beats < lim) lim = room_beats;
      if (32'(rem_q) < 32'(lim)) lim = 13'(rem_q);
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      bl_d      = bl_q;
      beat_d    = beat_q;
      busy_d    = busy_q;
      cmd_ready = 1'b0;
      s_ready   = 1'b0;
      aw_valid  = 1'b0;
      w_valid   = 1'b0;
      w_last    = 1'b0;
      done      = 1'b0;
      done_err  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               rem_d   = cmd_beats;
               busy_d  = 1'b1;
               state_d = (cmd_beats == '0) ? S_FIN : S_CALC;
            end
         end
         S_CALC: begin
            bl_d = BL_W'(lim);
            if (outst_q < OS_W'(MAX_OUTST)) state_d = S_ADDR;
         end
         S_ADDR: begin
            aw_valid = 1'b1;
            if (aw_ready) begin
               beat_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            s_ready = w_ready;
            w_valid = s_valid;
            w_last  = (beat_q == bl_q - BL_W'(1));
            if (s_valid && w_ready) begin
               rem_d  = rem_q - LEN_W'(1);
               beat_d = beat_q + BL_W'(1);
               if (w_last) begin
                  addr_d  = addr_q + (ADDR_W'(bl_q) << SZ);
                  state_d = (rem_d != '0) ? S_CALC : S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (outst_q == '0) state_d = S_FIN;
         end
         S_FIN: begin
            done     = 1'b1;
            done_err = err_q;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign aw_addr  = addr_q;
   assign aw_len   = 8'(bl_q - BL_W'(1));
   assign aw_size  = 3'(SZ);
   assign aw_burst = 2'b01;
   assign aw_id    = '0;
   assign w_data   = s_data;
   assign w_strb   = '1;
   assign b_ready  = 1'b1;
   assign busy     = busy_q;

   assign aw_hs = aw_valid & aw_ready;
   assign b_hs  = b_valid & b_ready;
   assign b_err = (b_resp == 2'b10) || (b_resp == 2'b11);

   // A stray B with nothing outstanding leaves the count pinned at zero.
   always_comb begin
      outst_d = outst_q;
      if (aw_hs && !b_hs) begin
         outst_d = outst_q + OS_W'(1);
      end else if (b_hs && !aw_hs && outst_q != '0) begin
         outst_d = outst_q - OS_W'(1);
      end
      err_d = err_q | (b_hs & b_err);
      if (state_q == S_FIN) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         bl_q    <= '0;
         beat_q  <= '0;
         outst_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         bl_q    <= bl_d;
         beat_q  <= beat_d;
         outst_q <= outst_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   a_b_outst: assert property (
      @(posedge clk) disable iff (!rstn) b_valid |-> (outst_q != '0));

   a_aw_hold: assert property (
      @(posedge clk) disable iff (!rstn)
      (aw_valid && !aw_ready) |=>
      (aw_valid && $stable(aw_addr) && $stable(aw_len)));

endmodule

// File: tb/tb_dma_axi_wr_engine.sv
// tb_dma_axi_wr_engine: directed and stall-randomised checks of the
// DMA write engine against a burst-splitting reference model.
`timescale 1ns/1ps
module tb_dma_axi_wr_engine;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LW = 20;
   localparam int MB = 16;
   localparam int MO = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [LW-1:0] cmd_beats;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          done;
   logic          done_err;
   logic          busy;
   logic          aw_valid;
   logic          aw_ready;
   logic [AW-1:0] aw_addr;
   logic [7:0]    aw_len;
   logic [2:0]    aw_size;
   logic [1:0]    aw_burst;
   logic [3:0]    aw_id;
   logic          w_valid;
   logic          w_ready;
   logic [DW-1:0] w_data;
   logic [7:0]    w_strb;
   logic          w_last;
   logic          b_valid;
   logic          b_ready;
   logic [1:0]    b_resp;

   always #5 clk = ~clk;

   dma_axi_wr_engine #(
      .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
      .MAX_BURST(MB), .MAX_OUTST(MO)
   ) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .done(done), .done_err(done_err), .busy(busy),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_id(aw_id),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
   );

   typedef struct {
      logic [63:0] addr;
      int          beats;
      int          err_burst;
      logic [1:0]  code;
   } cmd_t;

   typedef struct {
      logic [63:0] addr;
      int          len;
      logic [1:0]  resp;
   } burst_t;

   typedef struct {
      int         beats;
      logic [1:0] resp;
   } wb_t;

   cmd_t       cmd_q[$];
   burst_t     exp_aw_q[$];
   burst_t     aw_log[$];
   wb_t        w_q[$];
   logic [1:0] b_q[$];
   logic       exp_done_q[$];

   int vec = 0;
   int errs = 0;
   int s_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
   int b_credit = 1 << 30;
   int src_n = 0, w_cnt = 0, w_beat = 0, outst_m = 0, cyc = 0;
   int aw_cnt = 0, wl_cnt = 0, b_cnt = 0, done_cnt = 0;
   int hs_cyc = 0, done_cyc = 0, b_at_done = 0;
   logic last_err = 1'b0;
   logic mbusy = 1'b0;
   logic prev_awv = 1'b0, prev_awr = 1'b0;
   logic [63:0] prev_awa = '0;
   logic [7:0]  prev_awl = '0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(int n);
      return {32'hC0DE_0000 + 32'(n) * 32'd7, 32'(n)};
   endfunction

   // Reference split: walk the command, cutting at MAX_BURST and at 4 KB pages.
   function automatic void plan(cmd_t c);
      logic [63:0] a = c.addr;
      int r = c.beats;
      int k = 0;
      int bl, room;
      logic e = 1'b0;
      logic [1:0] rs;
      while (r > 0) begin
         room = (4096 - int'(a % 4096)) / 8;
         bl = r;
         if (bl > MB) bl = MB;
         if (bl > room) bl = room;
         rs = (k == c.err_burst) ? c.code : 2'b00;
         if (rs[1]) e = 1'b1;
         exp_aw_q.push_back('{a, bl - 1, rs});
         a += 64'(bl * 8);
         r -= bl;
         k++;
      end
      exp_done_q.push_back(e);
   endfunction

   task automatic push_cmd(logic [63:0] a, int n, int eb, logic [1:0] code);
      cmd_q.push_back('{a, n, eb, code});
   endtask

   task automatic step();
      logic cmd_hs, aw_hs, w_hs, b_hs;
      @(negedge clk);
      cyc++;
      cmd_valid = cmd_q.size() > 0;
      cmd_addr  = '0;
      cmd_beats = '0;
      if (cmd_valid) begin
         cmd_addr  = cmd_q[0].addr;
         cmd_beats = LW'(cmd_q[0].beats);
      end
      s_valid  = $urandom_range(99) < s_pct;
      s_data   = pat(src_n);
      aw_ready = $urandom_range(99) < aw_pct;
      w_ready  = $urandom_range(99) < w_pct;
      b_valid  = b_q.size() > 0 && b_credit > 0 &&
                 $urandom_range(99) < b_pct;
      b_resp   = b_valid ? b_q[0] : 2'b00;
      #1;
      cmd_hs = cmd_valid && cmd_ready;
      aw_hs  = aw_valid && aw_ready;
      w_hs   = w_valid && w_ready;
      b_hs   = b_valid && b_ready;
      chk("b_ready", b_ready, 1);
      chk("busy", busy, mbusy);
      chk("cmd_ready", cmd_ready, !mbusy);
      chk("s_w_handshake", s_valid && s_ready, w_hs);
      if (w_valid) chk("w_before_aw", w_q.size() > 0, 1);
      if (prev_awv && !prev_awr) begin
         chk("aw_hold_valid", aw_valid, 1);
         chk("aw_hold_addr", aw_addr, prev_awa);
         chk("aw_hold_len", aw_len, prev_awl);
      end
      prev_awv = aw_valid;
      prev_awr = aw_ready;
      prev_awa = aw_addr;
      prev_awl = aw_len;
      if (aw_hs) begin
         aw_cnt++;
         aw_log.push_back('{aw_addr, int'(aw_len), 2'b00});
         chk("aw_expected", exp_aw_q.size() > 0, 1);
         if (exp_aw_q.size() > 0) begin
            chk("aw_addr", aw_addr, exp_aw_q[0].addr);
            chk("aw_len", aw_len, exp_aw_q[0].len);
            chk("aw_size", aw_size, 3);
            chk("aw_burst", aw_burst, 1);
            chk("aw_id", aw_id, 0);
            w_q.push_back('{exp_aw_q[0].len + 1, exp_aw_q[0].resp});
            void'(exp_aw_q.pop_front());
         end
      end
      if (w_hs) begin
         chk("w_data", w_data, pat(w_cnt));
         chk("w_strb", w_strb, 64'hFF);
         if (w_q.size() > 0) begin
            chk("w_last", w_last, w_beat == w_q[0].beats - 1);
            w_beat++;
            if (w_beat == w_q[0].beats) begin
               b_q.push_back(w_q[0].resp);
               void'(w_q.pop_front());
               w_beat = 0;
            end
         end
         if (w_last) wl_cnt++;
         w_cnt++;
      end
      if (s_valid && s_ready) src_n++;
      if (b_hs) begin
         void'(b_q.pop_front());
         b_cnt++;
         b_credit--;
      end
      outst_m += int'(aw_hs) - int'(b_hs);
      chk("outst_limit", outst_m <= MO, 1);
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         b_at_done = b_cnt;
         last_err  = done_err;
         chk("done_expected", exp_done_q.size() > 0, 1);
         if (exp_done_q.size() > 0) begin
            chk("done_err", done_err, exp_done_q[0]);
            void'(exp_done_q.pop_front());
         end
         chk("done_all_b", outst_m, 0);
         chk("done_all_w", w_q.size() + exp_aw_q.size(), 0);
         mbusy = 1'b0;
      end
      if (cmd_hs) begin
         mbusy  = 1'b1;
         hs_cyc = cyc;
         plan(cmd_q[0]);
         void'(cmd_q.pop_front());
      end
   endtask

   task automatic run_idle(int limit);
      int n = 0;
      while ((cmd_q.size() > 0 || mbusy || exp_done_q.size() > 0) &&
             n < limit) begin
         step();
         n++;
      end
      chk("run_timeout", n < limit, 1);
   endtask

   int a0, w0, l0, d0, b0, i0, n;
   int knobs[4][4] = '{'{100, 100, 100, 100}, '{70, 60, 50, 40},
                       '{50, 90, 30, 70}, '{30, 40, 80, 20}};

   initial begin
      cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
      s_valid = 1'b0; s_data = '0;
      aw_ready = 1'b0; w_ready = 1'b0;
      b_valid = 1'b0; b_resp = 2'b00;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_b_ready", b_ready, 1);
      @(negedge clk);
      rstn = 1'b1;

      // single aligned burst
      a0 = aw_cnt; w0 = w_cnt; l0 = wl_cnt; d0 = done_cnt; i0 = aw_log.size();
      push_cmd(64'h1000, 16, -1, 2'b00);
      run_idle(500);
      chk("t1_aw_n", aw_cnt - a0, 1);
      chk("t1_aw_addr", aw_log[i0].addr, 64'h1000);
      chk("t1_aw_len", aw_log[i0].len, 15);
      chk("t1_w_n", w_cnt - w0, 16);
      chk("t1_last_n", wl_cnt - l0, 1);
      chk("t1_done_n", done_cnt - d0, 1);
      chk("t1_done_err", last_err, 0);

      // 4 KB page split
      a0 = aw_cnt; w0 = w_cnt; i0 = aw_log.size();
      push_cmd(64'h0FC0, 32, -1, 2'b00);
      run_idle(500);
      chk("t2_aw_n", aw_cnt - a0, 3);
      chk("t2_aw0_addr", aw_log[i0].addr, 64'h0FC0);
      chk("t2_aw0_len", aw_log[i0].len, 7);
      chk("t2_aw1_addr", aw_log[i0 + 1].addr, 64'h1000);
      chk("t2_aw1_len", aw_log[i0 + 1].len, 15);
      chk("t2_aw2_addr", aw_log[i0 + 2].addr, 64'h1080);
      chk("t2_aw2_len", aw_log[i0 + 2].len, 7);
      chk("t2_w_n", w_cnt - w0, 32);

      // zero-beat command: FIN directly after the accepting edge
      a0 = aw_cnt; w0 = w_cnt; d0 = done_cnt;
      push_cmd(64'h2000, 0, -1, 2'b00);
      run_idle(100);
      chk("t3_aw_n", aw_cnt - a0, 0);
      chk("t3_w_n", w_cnt - w0, 0);
      chk("t3_done_n", done_cnt - d0, 1);
      chk("t3_done_lat", done_cyc - hs_cyc, 1);

      // outstanding limit with B withheld
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      b_credit = 0;
      push_cmd(64'h4000, 96, -1, 2'b00);
      repeat (120) step();
      chk("t4_aw_blocked", aw_cnt - a0, 2);
      chk("t4_w_unthrottled", w_cnt - w0, 32);
      b_credit = 1;
      n = 0;
      while (b_cnt == b0 && n < 50) begin step(); n++; end
      chk("t4_b_wait", n < 50, 1);
      repeat (40) step();
      chk("t4_aw_after_b", aw_cnt - a0, 3);
      b_credit = 1 << 30;
      run_idle(1000);
      chk("t4_aw_total", aw_cnt - a0, 6);
      chk("t4_b_before_done", b_at_done - b0, 6);

      // SLVERR on the 2nd of 3 bursts, then a clean command
      push_cmd(64'h5000, 48, 1, 2'b10);
      run_idle(500);
      chk("t5_done_err", last_err, 1);
      push_cmd(64'h6000, 16, -1, 2'b00);
      run_idle(500);
      chk("t5_next_clean", last_err, 0);

      // stall-randomised commands
      a0 = aw_cnt; l0 = wl_cnt; d0 = done_cnt;
      for (int p = 0; p < 4; p++) begin
         s_pct = knobs[p][0]; aw_pct = knobs[p][1];
         w_pct = knobs[p][2]; b_pct = knobs[p][3];
         for (int c = 0; c < 50; c++) begin
            logic [63:0] ra;
            int eb;
            ra = 64'($urandom_range(0, 15)) * 4096;
            if ($urandom_range(1) == 1)
               ra += 64'($urandom_range(480, 511)) * 8;
            else
               ra += 64'($urandom_range(0, 511)) * 8;
            eb = ($urandom_range(7) == 0) ? int'($urandom_range(0, 2)) : -1;
            push_cmd(ra, int'($urandom_range(0, 40)), eb,
                     ($urandom_range(1) == 1) ? 2'b11 : 2'b10);
         end
         run_idle(20000);
      end
      chk("rand_last_eq_aw", wl_cnt - l0, aw_cnt - a0);
      chk("rand_done_n", done_cnt - d0, 200);

      // reset in the middle of a transfer
      s_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100;
      w0 = w_cnt;
      push_cmd(64'h7000, 64, -1, 2'b00);
      n = 0;
      while (w_cnt - w0 < 5 && n < 100) begin step(); n++; end
      chk("t7_started", n < 100, 1);
      rstn = 1'b0;
      #1;
      chk("t7_aw_valid", aw_valid, 0);
      chk("t7_w_valid", w_valid, 0);
      chk("t7_s_ready", s_ready, 0);
      chk("t7_cmd_ready", cmd_ready, 1);
      chk("t7_busy", busy, 0);
      chk("t7_done", done, 0);
      cmd_q.delete(); exp_aw_q.delete(); w_q.delete();
      b_q.delete(); exp_done_q.delete();
      mbusy = 1'b0; outst_m = 0; w_beat = 0; src_n = w_cnt;
      prev_awv = 1'b0;
      cmd_valid = 1'b0; s_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      a0 = aw_cnt; d0 = done_cnt;
      push_cmd(64'h8000, 20, -1, 2'b00);
      run_idle(500);
      chk("t7_after_aw", aw_cnt - a0, 2);
      chk("t7_after_done", done_cnt - d0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
